// File: rtl/sw_pkg.sv
// Shared constants for the stopwatch button-control slice.
// Holds the FSM state encodings (also driven out on state_o for LEDs)
// and the default timing parameters used by sw_btn_ctrl and its debouncer.
package sw_pkg;

  // Two-bit state encodings, kept as plain constants so they map 1:1 to state_o.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LAP  = 2'b10;
  localparam logic [1:0] ST_STOP = 2'b11;

  // Default timing, in tick_100 periods unless noted.
  localparam int SYNC_STAGES_DEF = 4;    // flops per button synchroniser
  localparam int DEB_TICKS_DEF   = 5;    // hysteresis reload
  localparam int LONG_TICKS_DEF  = 100;  // 1 s hold = long press
  localparam int HOLD_W_DEF      = 7;    // 2**HOLD_W > LONG_TICKS

endpackage

// File: rtl/sw_btn_debounce.sv
// Purpose : synchronise one raw button, apply tick-based hysteresis, and
//           produce registered press/release strobes.
// Ports   : clk, rst (async, high), tick_100 (100 Hz strobe), btn_raw (async input)
//           -> btn_h (debounced level), press / release_evt (one-clk strobes).
// Latency : raw edge -> btn_h = SYNC_STAGES+1 clk; btn_h edge -> strobe = 1 clk.
module sw_btn_debounce
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,  // must be >= 2
  parameter int DEB_TICKS   = DEB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_100,
  input  logic btn_raw,
  output logic btn_h,
  output logic press,
  output logic release_evt  // 'release' is a reserved word in SystemVerilog
);

  localparam int CNT_W = $clog2(DEB_TICKS + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_btn_h_d;
  logic                   r_press;
  logic                   r_release;
  logic                   w_btn_s;
  logic                   w_btn_h;

  assign w_btn_s = r_sync[SYNC_STAGES-1];
  assign w_btn_h = (r_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_btn_h_d <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      // Any high sample reloads the window, so a short glitch can only
      // stretch the held level, never split it into two presses.
      if (w_btn_s) begin
        r_cnt <= CNT_W'(DEB_TICKS);
      end else if (tick_100 && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      r_btn_h_d <= w_btn_h;
      r_press   <= w_btn_h & ~r_btn_h_d;
      r_release <= ~w_btn_h & r_btn_h_d;
    end
  end

  assign btn_h       = w_btn_h;
  assign press       = r_press;
  assign release_evt = r_release;

endmodule

// File: rtl/sw_btn_ctrl.sv
// Purpose : stopwatch mode control - debounces START/STOP and LAP, measures the
//           START hold time and runs the IDLE/RUN/LAP/STOP FSM.
// Ports   : clk, rst (async, high), tick_100, btn_ss, btn_lap
//           -> run, freeze (state-decoded), lap_pls, clear_pls (one-clk), state_o.
// Latency : btn_h -> state change = 2 clk; pulses appear with the new state.
module sw_btn_ctrl
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_TICKS   = DEB_TICKS_DEF,
  parameter int LONG_TICKS  = LONG_TICKS_DEF,
  parameter int HOLD_W      = HOLD_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       run,
  output logic       freeze,
  output logic       lap_pls,
  output logic       clear_pls,
  output logic [1:0] state_o
);

  logic              w_ss_h, w_ss_press, w_ss_rel;
  logic              w_lap_h, w_lap_press, w_lap_rel;
  logic              w_unused;
  logic [HOLD_W-1:0] r_hold;
  logic              r_long_seen;
  logic              w_long_pls;
  logic              w_ss_evt;
  logic [1:0]        r_state, w_state_nxt;
  logic              r_lap_pls, r_clear_pls;
  logic              w_lap_nxt, w_clear_nxt;

  sw_btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_TICKS(DEB_TICKS)) u_deb_ss (
    .clk(clk), .rst(rst), .tick_100(tick_100), .btn_raw(btn_ss),
    .btn_h(w_ss_h), .press(w_ss_press), .release_evt(w_ss_rel)
  );

  sw_btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_TICKS(DEB_TICKS)) u_deb_lap (
    .clk(clk), .rst(rst), .tick_100(tick_100), .btn_raw(btn_lap),
    .btn_h(w_lap_h), .press(w_lap_press), .release_evt(w_lap_rel)
  );

  // LAP only acts on its press edge.
  assign w_unused = &{1'b0, w_lap_h, w_lap_rel};

  // Long-press fires on the tick that carries the counter onto LONG_TICKS;
  // a coincident press restarts the count instead.
  assign w_long_pls = w_ss_h && tick_100 && !w_ss_press &&
                      (r_hold == HOLD_W'(LONG_TICKS - 1));

  // A short press acts on release; a release that ends a long press is swallowed.
  assign w_ss_evt = w_ss_rel & ~r_long_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_long_seen <= 1'b0;
    end else if (w_ss_press) begin
      r_hold      <= '0;
      r_long_seen <= 1'b0;
    end else begin
      if (w_ss_h && tick_100 && (r_hold != HOLD_W'(LONG_TICKS))) begin
        r_hold <= r_hold + 1'b1;
      end
      if (w_long_pls) begin
        r_long_seen <= 1'b1;
      end
    end
  end

  // Priority: long press > START/STOP event > LAP press.
  always_comb begin
    w_state_nxt = r_state;
    w_lap_nxt   = 1'b0;
    w_clear_nxt = 1'b0;
    if (w_long_pls) begin
      w_state_nxt = ST_IDLE;
      w_clear_nxt = 1'b1;
    end else if (w_ss_evt) begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_STOP;
        ST_LAP:  w_state_nxt = ST_STOP;
        default: w_state_nxt = ST_RUN;
      endcase
    end else if (w_lap_press) begin
      case (r_state)
        ST_RUN: begin
          w_state_nxt = ST_LAP;
          w_lap_nxt   = 1'b1;
        end
        ST_LAP:  w_state_nxt = ST_RUN;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          w_clear_nxt = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lap_pls   <= 1'b0;
      r_clear_pls <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lap_pls   <= w_lap_nxt;
      r_clear_pls <= w_clear_nxt;
    end
  end

  assign run       = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign freeze    = (r_state == ST_LAP);
  assign lap_pls   = r_lap_pls;
  assign clear_pls = r_clear_pls;
  assign state_o   = r_state;

endmodule

// File: tb/tb_sw_btn_ctrl.sv
// Bench for sw_btn_ctrl: table of button actions with expected state/outputs
// and pulse counts, followed by hand-written sequences for reset, long press,
// coincident events, button held across reset and contact bounce.
module tb_sw_btn_ctrl;
  import sw_pkg::*;

  localparam int A_SS   = 0;  // START/STOP held 30 clk
  localparam int A_LAP  = 1;  // LAP held 30 clk
  localparam int A_LONG = 2;  // START/STOP held 1200 clk
  localparam int NV     = 13;

  typedef struct {
    int         act;
    logic [1:0] st;
    logic       run;
    logic       frz;
    int         laps;
    int         clrs;
    string      nm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, btn_ss, btn_lap;
  logic       tick_100, tick_ph, tick_man, tick_auto;
  logic       run, freeze, lap_pls, clear_pls;
  logic [1:0] state_o;

  int n_run  = 0;
  int n_fail = 0;
  int lap_cnt = 0, clr_cnt = 0, wide_err = 0;
  logic lap_prev = 1'b0, clr_prev = 1'b0;
  int ph = 0;
  vec_t vec[NV];

  sw_btn_ctrl dut (
    .clk(clk), .rst(rst), .tick_100(tick_100), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .run(run), .freeze(freeze), .lap_pls(lap_pls), .clear_pls(clear_pls),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Free-running 1-in-10 tick, or a manually driven tick when tick_auto=0.
  assign tick_100 = tick_auto ? tick_ph : tick_man;
  initial begin
    tick_ph = 1'b0;
    forever begin
      @(negedge clk);
      tick_ph = (ph == 9);
      ph = (ph + 1) % 10;
    end
  end

  // Pulse monitor: counts pulses and flags any that last more than one clk.
  always @(negedge clk) begin
    if (lap_pls) begin
      if (lap_prev) wide_err++;
      else lap_cnt++;
    end
    if (clear_pls) begin
      if (clr_prev) wide_err++;
      else clr_cnt++;
    end
    lap_prev = lap_pls;
    clr_prev = clear_pls;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input int act, input logic [1:0] st, input logic r,
                      input logic f, input int l, input int c, input string nm);
    vec[i].act = act; vec[i].st = st; vec[i].run = r; vec[i].frz = f;
    vec[i].laps = l; vec[i].clrs = c; vec[i].nm = nm;
  endtask

  task automatic push(input int which, input int len);
    if (which == A_LAP) btn_lap = 1'b1;
    else btn_ss = 1'b1;
    repeat (len) @(negedge clk);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (150) @(negedge clk);
  endtask

  initial begin
    int l0, c0;
    rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; tick_auto = 1'b1; tick_man = 1'b0;

    setv(0,  A_LAP,  ST_IDLE, 0, 0, 0, 0, "idle_lap");
    setv(1,  A_SS,   ST_RUN,  1, 0, 0, 0, "idle_ss");
    setv(2,  A_LAP,  ST_LAP,  1, 1, 1, 0, "run_lap");
    setv(3,  A_LAP,  ST_RUN,  1, 0, 0, 0, "lap_lap");
    setv(4,  A_LAP,  ST_LAP,  1, 1, 1, 0, "run_lap2");
    setv(5,  A_SS,   ST_STOP, 0, 0, 0, 0, "lap_ss");
    setv(6,  A_SS,   ST_RUN,  1, 0, 0, 0, "stop_ss");
    setv(7,  A_SS,   ST_STOP, 0, 0, 0, 0, "run_ss");
    setv(8,  A_LAP,  ST_IDLE, 0, 0, 0, 1, "stop_lap");
    setv(9,  A_SS,   ST_RUN,  1, 0, 0, 0, "idle_ss2");
    setv(10, A_LONG, ST_IDLE, 0, 0, 0, 1, "run_long");
    setv(11, A_LONG, ST_IDLE, 0, 0, 0, 1, "idle_long");
    setv(12, A_SS,   ST_RUN,  1, 0, 0, 0, "idle_ss3");

    repeat (3) @(negedge clk);
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_run", run, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_lap", lap_pls, 0);
    chk("rst_clear", clear_pls, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      l0 = lap_cnt;
      c0 = clr_cnt;
      push(vec[i].act, (vec[i].act == A_LONG) ? 1200 : 30);
      chk($sformatf("%s/state", vec[i].nm), state_o, vec[i].st);
      chk($sformatf("%s/run", vec[i].nm), run, vec[i].run);
      chk($sformatf("%s/freeze", vec[i].nm), freeze, vec[i].frz);
      chk($sformatf("%s/lap_pls", vec[i].nm), lap_cnt - l0, vec[i].laps);
      chk($sformatf("%s/clear_pls", vec[i].nm), clr_cnt - c0, vec[i].clrs);
    end

    // Long press from RUN, observed before and after the 100th tick.
    c0 = clr_cnt;
    btn_ss = 1'b1;
    repeat (900) @(negedge clk);
    chk("long_mid_state", state_o, ST_RUN);
    chk("long_mid_clear", clr_cnt - c0, 0);
    repeat (300) @(negedge clk);
    chk("long_end_state", state_o, ST_IDLE);
    chk("long_end_clear", clr_cnt - c0, 1);
    btn_ss = 1'b0;
    repeat (150) @(negedge clk);
    chk("long_rel_state", state_o, ST_IDLE);
    chk("long_rel_clear", clr_cnt - c0, 1);

    // Coincident LAP press and START/STOP release in RUN, tick driven by hand
    // so both registered strobes land on the same clock.
    push(A_SS, 30);
    chk("coin_pre_state", state_o, ST_RUN);
    l0 = lap_cnt;
    btn_ss = 1'b1;
    repeat (30) @(negedge clk);
    tick_auto = 1'b0;
    tick_man  = 1'b0;
    btn_ss    = 1'b0;
    repeat (4) @(negedge clk);
    btn_lap  = 1'b1;
    tick_man = 1'b1;
    repeat (5) @(negedge clk);
    tick_man = 1'b0;
    chk("coin_hold_state", state_o, ST_RUN);
    repeat (2) @(negedge clk);
    chk("coin_state", state_o, ST_STOP);
    chk("coin_freeze", freeze, 0);
    tick_auto = 1'b1;
    btn_lap   = 1'b0;
    repeat (150) @(negedge clk);
    chk("coin_lap_pls", lap_cnt - l0, 0);
    chk("coin_after_state", state_o, ST_STOP);

    // Reset asserted while running takes effect without a clock edge.
    push(A_SS, 30);
    chk("mid_pre_run", run, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", state_o, ST_IDLE);
    chk("mid_rst_run", run, 0);
    chk("mid_rst_freeze", freeze, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_pulses", {lap_pls, clear_pls}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rel_state", state_o, ST_IDLE);
    push(A_SS, 30);
    chk("mid_recover", state_o, ST_RUN);

    // START held across reset release: fresh press, no spurious event.
    btn_ss = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_rst_state", state_o, ST_IDLE);
    btn_ss = 1'b0;
    repeat (150) @(negedge clk);
    chk("held_rel_state", state_o, ST_RUN);

    // Contact bounce in RUN: one press/release must give exactly one event.
    for (int k = 0; k < 14; k++) begin
      btn_ss = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    btn_ss = 1'b0;
    repeat (150) @(negedge clk);
    chk("bounce_state", state_o, ST_STOP);
    chk("bounce_run", run, 0);

    chk("pulse_width", wide_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
